// File: rtl/spi_byte_receiver.sv
// -----------------------------------------------------------------------------
// spi_byte_receiver
//
// Receive side of the three-wire SPI link (forwarded clock, enable, data).
// The three SPI lines are oversampled in the local clk domain through
// synchronizer chains. Words arrive MSB first and are rebuilt from them. Each
// completed word is offered downstream on a valid/ready interface.
//
// Ports
//   clk        in   local system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   spi_clk    in   forwarded transmitter clock (asynchronous to clk)
//   spi_en     in   transmitter enable, high while a frame is in progress
//   spi_data   in   serial data, MSB first
//   out_data   out  last completed word
//   out_valid  out  out_data holds an unconsumed word
//   out_ready  in   downstream accepts on out_valid & out_ready
//   busy       out  high while a word is being shifted in
//   overrun    out  one-cycle pulse when a completed word is dropped
//   frame_err  out  one-cycle pulse when spi_en drops mid-word
// -----------------------------------------------------------------------------
module spi_byte_receiver #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_en,
  input  logic              spi_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overrun,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] en_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   sclk_prev_q;

  logic sclk_s;
  logic en_s;
  logic dat_s;
  logic rise;

  state_e            state_q,     state_d;
  logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [DATA_W-1:0] sr_q,        sr_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q,   overrun_d;
  logic              frame_err_q, frame_err_d;

  logic              word_done;
  logic [DATA_W-1:0] sr_shifted;

  // Synchronizer chains: bit 0 is the first stage, the top bit is the synced copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      en_sync_q   <= '0;
      dat_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      en_sync_q   <= {en_sync_q[SYNC_STAGES-2:0],   spi_en};
      dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0],  spi_data};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign en_s       = en_sync_q[SYNC_STAGES-1];
  assign dat_s      = dat_sync_q[SYNC_STAGES-1];
  assign rise       = sclk_s & ~sclk_prev_q;
  assign sr_shifted = {sr_q[DATA_W-2:0], dat_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    word_done   = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        sr_d      = '0;
        if (rise && en_s) begin
          sr_d      = {{(DATA_W-1){1'b0}}, dat_s};
          bit_cnt_d = CNT_W'(1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // Losing enable takes priority: a partial word is never delivered.
        if (!en_s) begin
          frame_err_d = 1'b1;
          sr_d        = '0;
          bit_cnt_d   = '0;
          state_d     = IDLE;
        end else if (rise) begin
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            word_done = 1'b1;
            sr_d      = '0;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            sr_d      = sr_shifted;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Output stage: a completion can replace a word that is being consumed in
    // the same cycle; otherwise a held word wins and the new one is dropped.
    if (word_done) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = sr_shifted;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == SHIFT);
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_byte_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_byte_receiver
//
// Scoreboard bench: every word sent is pushed as an expected value. A monitor
// pops the queue on each accepted beat and compares. Scenario tasks add their
// own timing and flag checks.
// -----------------------------------------------------------------------------
module tb_spi_byte_receiver;

  localparam int DATA_W = 8;
  localparam int SYNC   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              spi_clk = 1'b0;
  logic              spi_en = 1'b0;
  logic              spi_data = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              busy;
  logic              overrun;
  logic              frame_err;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  int ovr_cnt  = 0;
  int fe_cnt   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_v;

  spi_byte_receiver #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_clk   (spi_clk),
    .spi_en    (spi_en),
    .spi_data  (spi_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Monitor: pops the scoreboard on each accepted beat, counts pulse cycles.
  always @(negedge clk) begin
    if (overrun)   ovr_cnt++;
    if (frame_err) fe_cnt++;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_unexpected got=%h expected=none", out_data);
      end else begin
        exp_v = exp_q.pop_front();
        pops++;
        if (out_data !== exp_v) begin
          failures++;
          $display("FAIL scoreboard_data got=%h expected=%h", out_data, exp_v);
        end
      end
    end
  end

  // All stimulus changes 2 time units after a rising clk edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic bit_hi(input logic b);
    tick();
    spi_data = b;
    repeat (3) tick();
    spi_clk = 1'b1;
  endtask

  task automatic bit_lo();
    repeat (4) tick();
    spi_clk = 1'b0;
  endtask

  task automatic send_bits(input logic [DATA_W-1:0] v, input int n);
    for (int i = DATA_W - 1; i > DATA_W - 1 - n; i--) begin
      bit_hi(v[i]);
      bit_lo();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({out_valid, busy, overrun, frame_err, out_data} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=0", {out_valid, busy, overrun, frame_err, out_data});
    end
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle valid=%b busy=%b required=0/0", out_valid, busy);
    end
  endtask

  task automatic test_single();
    int p0;
    p0 = pops;
    out_ready = 1'b1;
    tick();
    spi_en = 1'b1;
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 7);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL single_busy got=%b required=1", busy);
    end
    bit_hi(1'b1);
    @(negedge clk);                   // before edge T
    @(negedge clk);                   // after T
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_valid_T got=%b required=0", out_valid);
    end
    @(negedge clk);                   // after T+1
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_valid_T1 got=%b required=0", out_valid);
    end
    @(negedge clk);                   // after T+2
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_valid_T2 valid=%b data=%h required=1/a5", out_valid, out_data);
    end
    @(negedge clk);                   // after T+3
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_after valid=%b busy=%b required=0/0", out_valid, busy);
    end
    bit_lo();
    tick();
    spi_en = 1'b0;
    repeat (6) tick();
    checks++;
    if (pops - p0 != 1) begin
      failures++;
      $display("FAIL single_beats got=%0d required=1", pops - p0);
    end
  endtask

  task automatic test_back_to_back();
    int p0, f0;
    p0 = pops;
    f0 = fe_cnt;
    out_ready = 1'b1;
    tick();
    spi_en = 1'b1;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_bits(8'h3C, 8);
    send_bits(8'hC3, 8);
    repeat (6) tick();
    spi_en = 1'b0;
    repeat (8) tick();
    checks++;
    if (pops - p0 != 2) begin
      failures++;
      $display("FAIL b2b_beats got=%0d required=2", pops - p0);
    end
    checks++;
    if (fe_cnt != f0) begin
      failures++;
      $display("FAIL b2b_frame_err got=%0d required=0", fe_cnt - f0);
    end
  endtask

  task automatic test_overrun();
    int o0;
    o0 = ovr_cnt;
    out_ready = 1'b0;
    tick();
    spi_en = 1'b1;
    exp_q.push_back(8'h11);
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    repeat (6) tick();
    spi_en = 1'b0;
    @(negedge clk);
    checks++;
    if (ovr_cnt - o0 != 1) begin
      failures++;
      $display("FAIL overrun_pulses got=%0d required=1", ovr_cnt - o0);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      failures++;
      $display("FAIL overrun_hold valid=%b data=%h required=1/11", out_valid, out_data);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h11) begin
      failures++;
      $display("FAIL overrun_drain valid=%b data=%h required=0/11", out_valid, out_data);
    end
    repeat (4) tick();
  endtask

  task automatic test_simultaneous();
    int o0;
    o0 = ovr_cnt;
    out_ready = 1'b0;
    tick();
    spi_en = 1'b1;
    exp_q.push_back(8'h55);
    send_bits(8'h55, 8);
    exp_q.push_back(8'hAA);
    send_bits(8'hAA, 7);
    bit_hi(1'b0);                     // spi_clk rises; edge T follows
    tick();                           // after T
    tick();                           // after T+1: completion is at T+2
    out_ready = 1'b1;
    @(negedge clk);                   // 0x55 accepted at T+2
    @(negedge clk);                   // after T+2
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hAA) begin
      failures++;
      $display("FAIL simul_load valid=%b data=%h required=1/aa", out_valid, out_data);
    end
    checks++;
    if (ovr_cnt != o0) begin
      failures++;
      $display("FAIL simul_overrun got=%0d required=0", ovr_cnt - o0);
    end
    bit_lo();
    tick();
    spi_en = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_truncated();
    int p0, f0;
    p0 = pops;
    f0 = fe_cnt;
    out_ready = 1'b1;
    tick();
    spi_en = 1'b1;
    send_bits(8'hB7, 5);
    tick();
    spi_en = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    checks++;
    if (fe_cnt - f0 != 1) begin
      failures++;
      $display("FAIL trunc_frame_err got=%0d required=1", fe_cnt - f0);
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || pops != p0) begin
      failures++;
      $display("FAIL trunc_state busy=%b valid=%b beats=%0d required=0/0/0", busy, out_valid, pops - p0);
    end
    tick();
    spi_en = 1'b1;
    exp_q.push_back(8'h0F);
    send_bits(8'h0F, 8);
    repeat (6) tick();
    spi_en = 1'b0;
    repeat (8) tick();
    checks++;
    if (pops - p0 != 1 || fe_cnt - f0 != 1) begin
      failures++;
      $display("FAIL trunc_recover beats=%0d ferr=%0d required=1/1", pops - p0, fe_cnt - f0);
    end
  endtask

  task automatic test_reset_mid();
    int p0, f0;
    out_ready = 1'b0;
    tick();
    spi_en = 1'b1;
    exp_q.push_back(8'h99);
    send_bits(8'h99, 8);
    send_bits(8'hA0, 3);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre valid=%b busy=%b required=1/1", out_valid, busy);
    end
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, overrun, frame_err, out_data} !== 12'h000) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b required=0", {out_valid, busy, overrun, frame_err, out_data});
    end
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    p0 = pops;
    f0 = fe_cnt;
    out_ready = 1'b1;
    repeat (4) tick();
    exp_q.push_back(8'hF0);
    send_bits(8'hF0, 8);
    repeat (6) tick();
    spi_en = 1'b0;
    repeat (8) tick();
    checks++;
    if (pops - p0 != 1 || fe_cnt != f0) begin
      failures++;
      $display("FAIL rstmid_recover beats=%0d ferr=%0d required=1/0", pops - p0, fe_cnt - f0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_simultaneous();
    test_truncated();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
